// File: rtl/mcse_multi_ip_auth_sequencer.sv
// Boot-time authentication sequencer: fetches each IP's golden PUF signature from
// secure memory and runs a PCM compare with timeout and bounded retry per IP.
//
// state       | meaning
// S_IDLE      | after reset, waiting for start with lc_success
// S_MEM_REQ   | one-cycle read strobe for the current IP's signature
// S_MEM_WAIT  | waiting for read data or memory timeout
// S_PCM_ISSUE | one-cycle PCM compare request
// S_PCM_WAIT  | waiting for PCM response or timeout, retries on mismatch
// S_NEXT      | advance to the next IP or finish
// S_DONE      | run complete (or aborted), bitmaps held
module mcse_multi_ip_auth_sequencer #(
  parameter int NUM_IP     = 4,
  parameter int SIG_W      = 256,
  parameter int ID_W       = 32,
  parameter int MEM_LENGTH = 16,
  parameter int SIG_BASE   = 0,
  parameter int TIMEOUT    = 255,
  parameter int MAX_RETRY  = 2,
  localparam int MEM_AW    = (MEM_LENGTH > 1) ? $clog2(MEM_LENGTH) : 1,
  localparam int IDX_W     = $clog2(NUM_IP) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              lc_success,
  output logic              mem_rd_en,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [SIG_W-1:0]  mem_rdData,
  input  logic              mem_rdData_valid,
  output logic [SIG_W-1:0]  pcm_sig_in,
  output logic [ID_W-1:0]   pcm_IP_ID_in,
  output logic [2:0]        pcm_instruction_in,
  output logic              pcm_sig_valid,
  input  logic              pcm_A_c,
  input  logic              pcm_comp_out,
  output logic [NUM_IP-1:0] ip_pass,
  output logic [NUM_IP-1:0] ip_fail,
  output logic [IDX_W-1:0]  cur_ip,
  output logic              busy,
  output logic              done,
  output logic              abort
);

  localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [MEM_AW-1:0] ADDR_FIRST = MEM_AW'(SIG_BASE % MEM_LENGTH);
  localparam logic [MEM_AW-1:0] ADDR_LAST  = MEM_AW'(MEM_LENGTH - 1);
  localparam logic [TMR_W-1:0]  TMR_MAX    = TMR_W'(TIMEOUT);
  localparam logic [RTY_W-1:0]  RTY_MAX    = RTY_W'(MAX_RETRY);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_IP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MEM_REQ,
    S_MEM_WAIT,
    S_PCM_ISSUE,
    S_PCM_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [RTY_W-1:0]  retry, retry_nxt;
  logic [TMR_W-1:0]  timer, timer_nxt;
  logic [MEM_AW-1:0] addr, addr_nxt;
  logic [NUM_IP-1:0] pass_nxt, fail_nxt;
  logic              abort_nxt;
  logic [SIG_W-1:0]  sig_nxt;
  logic [NUM_IP-1:0] idx_oh, hi_mask;
  logic              timed_out;

  assign idx_oh    = NUM_IP'(1) << idx;
  assign hi_mask   = ~(idx_oh - NUM_IP'(1));
  assign timed_out = (timer == TMR_MAX);

  assign busy               = (state != S_IDLE) && (state != S_DONE);
  assign done               = (state == S_DONE);
  assign mem_rd_en          = (state == S_MEM_REQ);
  assign mem_addr           = mem_rd_en ? addr : '0;
  assign pcm_sig_valid      = (state == S_PCM_ISSUE);
  assign pcm_instruction_in = busy ? 3'b001 : 3'b000;
  assign pcm_IP_ID_in       = ID_W'(idx);
  assign cur_ip             = idx;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    retry_nxt = retry;
    addr_nxt  = addr;
    pass_nxt  = ip_pass;
    fail_nxt  = ip_fail;
    abort_nxt = abort;
    sig_nxt   = pcm_sig_in;

    if (busy && !lc_success) begin
      // Lifecycle gate lost: everything not yet passed from idx upward is failed.
      state_nxt = S_DONE;
      abort_nxt = 1'b1;
      fail_nxt  = ip_fail | (hi_mask & ~ip_pass);
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start && lc_success) begin
            state_nxt = S_MEM_REQ;
            idx_nxt   = '0;
            retry_nxt = '0;
            addr_nxt  = ADDR_FIRST;
            pass_nxt  = '0;
            fail_nxt  = '0;
            abort_nxt = 1'b0;
          end
        end
        S_MEM_REQ: state_nxt = S_MEM_WAIT;
        S_MEM_WAIT: begin
          if (mem_rdData_valid) begin
            sig_nxt   = mem_rdData;
            state_nxt = S_PCM_ISSUE;
          end else if (timed_out) begin
            fail_nxt  = ip_fail | idx_oh;
            state_nxt = S_NEXT;
          end
        end
        S_PCM_ISSUE: state_nxt = S_PCM_WAIT;
        S_PCM_WAIT: begin
          if (pcm_A_c && pcm_comp_out) begin
            pass_nxt  = ip_pass | idx_oh;
            state_nxt = S_NEXT;
          end else if (pcm_A_c || timed_out) begin
            if (retry < RTY_MAX) begin
              retry_nxt = retry + 1'b1;
              state_nxt = S_PCM_ISSUE;
            end else begin
              fail_nxt  = ip_fail | idx_oh;
              state_nxt = S_NEXT;
            end
          end
        end
        S_NEXT: begin
          if (idx == IDX_LAST) begin
            state_nxt = S_DONE;
          end else begin
            idx_nxt   = idx + 1'b1;
            retry_nxt = '0;
            addr_nxt  = (addr == ADDR_LAST) ? '0 : addr + 1'b1;
            state_nxt = S_MEM_REQ;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end

    if (state_nxt != state) begin
      timer_nxt = '0;
    end else if (!timed_out) begin
      timer_nxt = timer + 1'b1;
    end else begin
      timer_nxt = timer;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      retry      <= '0;
      timer      <= '0;
      addr       <= '0;
      ip_pass    <= '0;
      ip_fail    <= '0;
      abort      <= 1'b0;
      pcm_sig_in <= '0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      retry      <= retry_nxt;
      timer      <= timer_nxt;
      addr       <= addr_nxt;
      ip_pass    <= pass_nxt;
      ip_fail    <= fail_nxt;
      abort      <= abort_nxt;
      pcm_sig_in <= sig_nxt;
    end
  end

endmodule

// File: tb/tb_mcse_multi_ip_auth_sequencer.sv
// Scoreboard bench: directed runs push expected memory addresses, PCM requests and
// final bitmaps; a negedge monitor pops and compares as the DUT presents them.
module tb_mcse_multi_ip_auth_sequencer;

  typedef struct packed {
    logic [3:0] pass;
    logic [3:0] fail;
    logic       abrt;
  } res_t;

  logic         clk;
  logic         rst;
  logic         start, lc_success;
  logic         mem_rd_en;
  logic [3:0]   mem_addr;
  logic [255:0] mem_rdData;
  logic         mem_rdData_valid;
  logic [255:0] pcm_sig_in;
  logic [31:0]  pcm_IP_ID_in;
  logic [2:0]   pcm_instruction_in;
  logic         pcm_sig_valid, pcm_A_c, pcm_comp_out;
  logic [3:0]   ip_pass, ip_fail;
  logic [2:0]   cur_ip;
  logic         busy, done, abort;

  logic         start_b, lc_b;
  logic         mem_rd_en_b;
  logic [3:0]   mem_addr_b;
  logic [255:0] mem_rdData_b;
  logic         mem_rdData_valid_b;
  logic [255:0] pcm_sig_in_b;
  logic [31:0]  pcm_IP_ID_in_b;
  logic [2:0]   pcm_instruction_in_b;
  logic         pcm_sig_valid_b, pcm_A_c_b, pcm_comp_out_b;
  logic [3:0]   ip_pass_b, ip_fail_b;
  logic [2:0]   cur_ip_b;
  logic         busy_b, done_b, abort_b;

  mcse_multi_ip_auth_sequencer #(.NUM_IP(4), .SIG_BASE(0)) dut (
    .clk(clk), .rst(rst), .start(start), .lc_success(lc_success),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdData(mem_rdData),
    .mem_rdData_valid(mem_rdData_valid), .pcm_sig_in(pcm_sig_in),
    .pcm_IP_ID_in(pcm_IP_ID_in), .pcm_instruction_in(pcm_instruction_in),
    .pcm_sig_valid(pcm_sig_valid), .pcm_A_c(pcm_A_c), .pcm_comp_out(pcm_comp_out),
    .ip_pass(ip_pass), .ip_fail(ip_fail), .cur_ip(cur_ip), .busy(busy),
    .done(done), .abort(abort)
  );

  mcse_multi_ip_auth_sequencer #(.NUM_IP(4), .SIG_BASE(14)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .lc_success(lc_b),
    .mem_rd_en(mem_rd_en_b), .mem_addr(mem_addr_b), .mem_rdData(mem_rdData_b),
    .mem_rdData_valid(mem_rdData_valid_b), .pcm_sig_in(pcm_sig_in_b),
    .pcm_IP_ID_in(pcm_IP_ID_in_b), .pcm_instruction_in(pcm_instruction_in_b),
    .pcm_sig_valid(pcm_sig_valid_b), .pcm_A_c(pcm_A_c_b), .pcm_comp_out(pcm_comp_out_b),
    .ip_pass(ip_pass_b), .ip_fail(ip_fail_b), .cur_ip(cur_ip_b), .busy(busy_b),
    .done(done_b), .abort(abort_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int rd3_cyc  = 0;
  int done_cyc = 0;
  logic sb_on  = 1'b1;
  logic done_q = 1'b0;

  logic [3:0] q_addr[$];
  int         q_pcm[$];
  res_t       q_res[$];
  logic [3:0] q_addr_b[$];

  // responder configuration
  int mem_lat  = 2;
  int pcm_lat  = 3;
  int mem_drop = -1;
  int mis[4];
  int attempts[4];
  int mem_cd = 0, pcm_cd = 0;
  logic [3:0] mem_pend_addr;
  logic pcm_res;
  logic mem_pend_b, pcm_pend_b;
  logic [3:0] addr_b_l;

  function automatic logic [255:0] sig_of(input int a);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(a) * 32'h0101_0101;
    return {8{w}};
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic flag(input string name);
    n_checks++;
    $display("FAIL %s: got unexpected event or timeout, expected none", name);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // memory and PCM models for both instances
  initial begin
    mem_rdData_valid = 1'b0; mem_rdData = '0; pcm_A_c = 1'b0; pcm_comp_out = 1'b0;
    mem_rdData_valid_b = 1'b0; mem_rdData_b = '0; pcm_A_c_b = 1'b0; pcm_comp_out_b = 1'b0;
    mem_pend_b = 1'b0; pcm_pend_b = 1'b0; addr_b_l = '0; pcm_res = 1'b0; mem_pend_addr = '0;
    forever begin
      @(negedge clk);
      mem_rdData_valid = 1'b0;
      pcm_A_c = 1'b0;
      pcm_comp_out = 1'b0;
      if (mem_cd > 0) begin
        mem_cd--;
        if (mem_cd == 0) begin
          mem_rdData_valid = 1'b1;
          mem_rdData = sig_of(int'(mem_pend_addr));
        end
      end
      if (mem_rd_en && int'(mem_addr) != mem_drop) begin
        mem_cd = mem_lat;
        mem_pend_addr = mem_addr;
      end
      if (pcm_cd > 0) begin
        pcm_cd--;
        if (pcm_cd == 0) begin
          pcm_A_c = 1'b1;
          pcm_comp_out = pcm_res;
        end
      end
      if (pcm_sig_valid && pcm_IP_ID_in < 32'd4) begin
        attempts[pcm_IP_ID_in[1:0]]++;
        pcm_res = attempts[pcm_IP_ID_in[1:0]] > mis[pcm_IP_ID_in[1:0]];
        pcm_cd = pcm_lat;
      end
      mem_rdData_valid_b = mem_pend_b;
      mem_rdData_b = sig_of(int'(addr_b_l));
      mem_pend_b = mem_rd_en_b;
      addr_b_l = mem_addr_b;
      pcm_A_c_b = pcm_pend_b;
      pcm_comp_out_b = pcm_pend_b;
      pcm_pend_b = pcm_sig_valid_b;
    end
  end

  // scoreboard monitor
  initial begin
    logic [3:0] ea;
    int eid;
    res_t er;
    forever begin
      @(negedge clk);
      if (sb_on) begin
        if (mem_rd_en) begin
          if (mem_addr == 4'd3) rd3_cyc = cyc;
          if (q_addr.size() == 0) flag("mem_rd_unexpected");
          else begin
            ea = q_addr.pop_front();
            check("mem_addr", mem_addr, ea);
          end
        end
        if (pcm_sig_valid) begin
          if (q_pcm.size() == 0) flag("pcm_req_unexpected");
          else begin
            eid = q_pcm.pop_front();
            check("pcm_ip_id", pcm_IP_ID_in, eid);
            check("pcm_sig", pcm_sig_in, sig_of(eid));
            check("pcm_instr", pcm_instruction_in, 3'b001);
          end
        end
        if (done && !done_q) begin
          done_cyc = cyc;
          if (q_res.size() == 0) flag("done_unexpected");
          else begin
            er = q_res.pop_front();
            check("ip_pass", ip_pass, er.pass);
            check("ip_fail", ip_fail, er.fail);
            check("abort", abort, er.abrt);
            check("pass_and_fail", ip_pass & ip_fail, 4'h0);
          end
        end
        if (mem_rd_en_b) begin
          if (q_addr_b.size() == 0) flag("mem_rd_b_unexpected");
          else begin
            ea = q_addr_b.pop_front();
            check("mem_addr_b", mem_addr_b, ea);
          end
        end
      end
      done_q = done;
    end
  end

  task automatic cfg(input int drop, input int m0, input int m1, input int m2, input int m3);
    mem_drop = drop;
    mis[0] = m0; mis[1] = m1; mis[2] = m2; mis[3] = m3;
    for (int i = 0; i < 4; i++) attempts[i] = 0;
  endtask

  task automatic push_run(input int pcm_ids[$], input logic [3:0] p, input logic [3:0] f,
                          input logic a);
    res_t r;
    for (int i = 0; i < 4; i++) q_addr.push_back(4'(i));
    foreach (pcm_ids[i]) q_pcm.push_back(pcm_ids[i]);
    r.pass = p; r.fail = f; r.abrt = a;
    q_res.push_back(r);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done) begin
      @(negedge clk);
      n++;
      if (n > budget) begin
        flag("wait_done_timeout");
        return;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_queues(input string name);
    check(name, q_addr.size() + q_pcm.size() + q_res.size(), 0);
  endtask

  initial begin
    bit got;
    rst = 1'b0; start = 1'b0; lc_success = 1'b1; start_b = 1'b0; lc_b = 1'b1;
    cfg(-1, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("rst_ctrl", {mem_rd_en, mem_addr, pcm_sig_valid, pcm_instruction_in, busy, done, abort}, 0);
    check("rst_bitmaps", {ip_pass, ip_fail, cur_ip, pcm_IP_ID_in}, 0);
    check("rst_sig", pcm_sig_in, 0);
    check("rst_b_addr", {mem_addr_b, busy_b, done_b}, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // start without lifecycle gate is ignored
    lc_success = 1'b0;
    pulse_start();
    repeat (4) @(negedge clk);
    check("nolc_busy", {busy, done}, 2'b00);
    lc_success = 1'b1;

    // all pass
    cfg(-1, 0, 0, 0, 0);
    push_run('{0, 1, 2, 3}, 4'hF, 4'h0, 1'b0);
    pulse_start();
    wait_done(1000);
    check_queues("q_all_pass");

    // IP2 mismatches twice, then matches
    cfg(-1, 0, 0, 2, 0);
    push_run('{0, 1, 2, 2, 2, 3}, 4'hF, 4'h0, 1'b0);
    pulse_start();
    wait_done(1000);
    check("ip2_attempts", attempts[2], 3);
    check_queues("q_retry_ok");

    // IP1 never matches
    cfg(-1, 0, 99, 0, 0);
    push_run('{0, 1, 1, 1, 2, 3}, 4'b1101, 4'b0010, 1'b0);
    pulse_start();
    wait_done(1000);
    check_queues("q_retry_fail");

    // IP3 memory never answers
    cfg(3, 0, 0, 0, 0);
    push_run('{0, 1, 2}, 4'b0111, 4'b1000, 1'b0);
    pulse_start();
    wait_done(1000);
    check("mem_timeout_cycles", done_cyc - rd3_cyc, 258);
    check_queues("q_mem_timeout");

    // lifecycle drop during IP1 PCM wait, late response must be ignored
    cfg(-1, 0, 0, 0, 0);
    q_addr.push_back(4'd0); q_addr.push_back(4'd1);
    q_pcm.push_back(0); q_pcm.push_back(1);
    q_res.push_back('{pass: 4'b0001, fail: 4'b1110, abrt: 1'b1});
    pulse_start();
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (pcm_sig_valid && pcm_IP_ID_in == 32'd1) got = 1'b1;
    end
    if (!got) flag("abort_pcm_wait_timeout");
    @(negedge clk) lc_success = 1'b0;
    wait_done(50);
    repeat (5) @(negedge clk);
    check("abort_late_pass", ip_pass, 4'b0001);
    check("abort_late_fail", ip_fail, 4'b1110);
    check("abort_sticky", abort, 1'b1);
    check_queues("q_abort");

    // gated start from DONE ignored; accepted start clears abort
    pulse_start();
    repeat (3) @(negedge clk);
    check("done_nolc_hold", {done, busy, abort}, 3'b101);
    lc_success = 1'b1;
    cfg(-1, 0, 0, 0, 0);
    push_run('{0, 1, 2, 3}, 4'hF, 4'h0, 1'b0);
    pulse_start();
    check("abort_cleared", abort, 1'b0);
    wait_done(1000);
    check_queues("q_rerun");

    // asynchronous reset mid-run
    sb_on = 1'b0;
    pulse_start();
    repeat (4) @(negedge clk);
    check("pre_rst_busy", busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_ctrl", {busy, done, mem_rd_en, pcm_sig_valid, abort, cur_ip, pcm_instruction_in}, 0);
    check("async_rst_sig", pcm_sig_in, 0);
    check("async_rst_maps", {ip_pass, ip_fail}, 0);
    @(negedge clk);
    mem_cd = 0; pcm_cd = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    sb_on = 1'b1;

    // SIG_BASE=14 wraps the address
    q_addr_b.push_back(4'd14); q_addr_b.push_back(4'd15);
    q_addr_b.push_back(4'd0);  q_addr_b.push_back(4'd1);
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (done_b) got = 1'b1;
    end
    if (!got) flag("wait_done_b_timeout");
    check("b_pass", ip_pass_b, 4'hF);
    check("b_fail", ip_fail_b, 4'h0);
    check("q_b_empty", q_addr_b.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
